axi_grid_link_arb: RTL and testbench

Output-link arbiter for one port of an `axi_grid` router node. It shares a single outgoing grid link between up to `NUM_REQ` requesters: the four neighbour inputs plus the local network interface (`axi_grid_mni`/`axi_grid_sni`). It grants round-robin and holds the grant for a whole packet until the `last` flit. The granted flit is registered into a one-entry output stage, so the link carries one flit per cycle at full throughput.

---
 rtl/axi_grid_pkg.sv | 25 ++
 rtl/axi_grid_rr_arb.sv | 44 ++++
 rtl/axi_grid_link_arb.sv | 133 +++++++++++++
 tb/tb_axi_grid_link_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_grid_pkg.sv
// -----------------------------------------------------------------------------
// axi_grid_pkg
// Shared types for the axi_grid router fabric:
//   flit_t            default opaque flit payload carried on a grid link
//   grid_port_e       router port numbering (N, E, S, W, LOCAL)
//   link_arb_state_e  output-link arbiter states
// -----------------------------------------------------------------------------
package axi_grid_pkg;

   typedef logic [31:0] flit_t;

   typedef enum logic [2:0] {
      PORT_N     = 3'd0,
      PORT_E     = 3'd1,
      PORT_S     = 3'd2,
      PORT_W     = 3'd3,
      PORT_LOCAL = 3'd4
   } grid_port_e;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } link_arb_state_e;

endpackage : axi_grid_pkg

// File: rtl/axi_grid_rr_arb.sv
// -----------------------------------------------------------------------------
// axi_grid_rr_arb
// Combinational round-robin picker. The search starts one past rr_ptr_i and
// wraps modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req_i       in   NUM_REQ  request vector
//   rr_ptr_i    in   IDX_W    index of the previous winner
//   gnt_idx_o   out  IDX_W    winning index (0 when nothing requests)
//   gnt_valid_o out  1        at least one request is asserted
// -----------------------------------------------------------------------------
module axi_grid_rr_arb #(
   parameter int NUM_REQ = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_valid_o
);

   // Priority scan from rr_ptr+1 with a single conditional wrap.
   always_comb begin
      int  sum;
      int  cand;
      logic found;
      sum         = 0;
      cand        = 0;
      found       = 1'b0;
      gnt_idx_o   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         sum  = int'(rr_ptr_i) + off;
         // rr_ptr_i < NUM_REQ, so one subtraction is enough to wrap.
         cand = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = IDX_W'(cand);
         end else begin
            found     = found;
         end
      end
      gnt_valid_o = found;
   end

endmodule : axi_grid_rr_arb

// File: rtl/axi_grid_link_arb.sv
// -----------------------------------------------------------------------------
// axi_grid_link_arb
// Output-link arbiter for one axi_grid router port. Grants round-robin among
// NUM_REQ inputs, holds the grant for a whole packet until the last flit, and
// registers the granted flit into a one-entry output stage (full throughput).
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   valid_i/last_i/flit_i/ready_o   per-input flit channel
//   valid_o/last_o/flit_o/ready_i   output link channel
//   gnt_idx_o          current or most recent grant holder
//   locked_o           a packet is in progress
// -----------------------------------------------------------------------------
module axi_grid_link_arb #(
   parameter type flit_t  = axi_grid_pkg::flit_t,
   parameter int  NUM_REQ = 5,
   parameter int  IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [NUM_REQ-1:0] last_i,
   input  flit_t              flit_i [NUM_REQ],
   output logic [NUM_REQ-1:0] ready_o,
   output logic               valid_o,
   output logic               last_o,
   output flit_t              flit_o,
   input  logic               ready_i,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               locked_o
);
   import axi_grid_pkg::*;

   link_arb_state_e  state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   flit_t            flit_q, flit_d;

   logic [IDX_W-1:0] arb_idx_s;
   logic             arb_valid_s;
   logic [IDX_W-1:0] cur_idx_s;
   logic             cur_valid_s;
   logic             can_load_s;
   logic             hs_s;

   axi_grid_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .req_i       (valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_idx_o   (arb_idx_s),
      .gnt_valid_o (arb_valid_s)
   );

   // Grant selection and upstream handshake; LOCKED ignores other requesters.
   always_comb begin
      can_load_s = !valid_q || ready_i;
      if (state_q == ARB_LOCKED) begin
         cur_idx_s   = gnt_idx_q;
         cur_valid_s = 1'b1;
      end else begin
         cur_idx_s   = arb_idx_s;
         cur_valid_s = arb_valid_s;
      end
      ready_o = '0;
      if (rst_ni && can_load_s && cur_valid_s) begin
         ready_o[cur_idx_s] = 1'b1;
      end else begin
         ready_o = '0;
      end
      hs_s = valid_i[cur_idx_s] && ready_o[cur_idx_s];
   end

   // Next state for the FSM, round-robin pointer and output stage.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      valid_d   = valid_q;
      last_d    = last_q;
      flit_d    = flit_q;
      if (hs_s) begin
         valid_d = 1'b1;
         last_d  = last_i[cur_idx_s];
         flit_d  = flit_i[cur_idx_s];
         // Pointer and grant index only move on a packet's first handshake.
         if (state_q == ARB_IDLE) begin
            rr_ptr_d  = cur_idx_s;
            gnt_idx_d = cur_idx_s;
         end else begin
            rr_ptr_d  = rr_ptr_q;
            gnt_idx_d = gnt_idx_q;
         end
         if (last_i[cur_idx_s]) begin
            state_d = ARB_IDLE;
         end else begin
            state_d = ARB_LOCKED;
         end
      end else if (ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // FSM and output-stage registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
         gnt_idx_q <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         flit_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         flit_q    <= flit_d;
      end
   end

   assign valid_o   = valid_q;
   assign last_o    = last_q;
   assign flit_o    = flit_q;
   assign gnt_idx_o = gnt_idx_q;
   assign locked_o  = (state_q == ARB_LOCKED);

endmodule : axi_grid_link_arb

// File: tb/tb_axi_grid_link_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_grid_link_arb
// Directed scenarios; expected output flits are queued up front and a monitor
// compares every output-link transfer against the queue head.
// -----------------------------------------------------------------------------
module tb_axi_grid_link_arb;
   import axi_grid_pkg::*;

   localparam int N = 5;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  valid_i;
   logic [N-1:0]  last_i;
   flit_t         flit_i [N];
   logic [N-1:0]  ready_o;
   logic          valid_o;
   logic          last_o;
   flit_t         flit_o;
   logic          ready_i;
   logic [2:0]    gnt_idx_o;
   logic          locked_o;

   int            n_checks;
   int            n_fail;
   logic [31:0]   exp_flit_q [$];
   logic          exp_last_q [$];
   logic [31:0]   mon_flit;
   logic          mon_last;

   axi_grid_link_arb dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .valid_i   (valid_i),
      .last_i    (last_i),
      .flit_i    (flit_i),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .last_o    (last_o),
      .flit_o    (flit_o),
      .ready_i   (ready_i),
      .gnt_idx_o (gnt_idx_o),
      .locked_o  (locked_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int src, input int seq);
      return {16'hC0DE, 8'(src), 8'(seq)};
   endfunction

   task automatic expect_flit(input logic [31:0] f, input logic l);
      exp_flit_q.push_back(f);
      exp_last_q.push_back(l);
   endtask

   // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      valid_i = '0;
      last_i  = '0;
      ready_i = 1'b1;
      for (int i = 0; i < N; i++) flit_i[i] = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      valid_i = 5'b11111;
      rst_n   = 1'b0;
      smp();
      chk("rst_ready_forced", 32'(ready_o), 32'h0);
      tick();
      smp();
      chk("rst_valid_o", 32'(valid_o), 32'h0);
      chk("rst_last_o", 32'(last_o), 32'h0);
      chk("rst_flit_o", flit_o, 32'h0);
      chk("rst_gnt_idx", 32'(gnt_idx_o), 32'h0);
      chk("rst_locked", 32'(locked_o), 32'h0);
      tick();
      rst_n = 1'b1;
      clear_inputs();
   endtask

   // Scoreboard monitor: each output transfer must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         if (exp_flit_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got flit %0h expected none (t=%0t)", flit_o, $time);
         end else begin
            mon_flit = exp_flit_q.pop_front();
            mon_last = exp_last_q.pop_front();
            chk("sb_flit", flit_o, mon_flit);
            chk("sb_last", 32'(last_o), 32'(mon_last));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      clear_inputs();

      // ---------------- single-flit packet on input 2 ----------------
      do_reset();
      expect_flit(mk(2, 0), 1'b1);
      valid_i[2] = 1'b1; last_i[2] = 1'b1; flit_i[2] = mk(2, 0);
      smp();
      chk("single_ready", 32'(ready_o), 32'h04);
      tick();
      clear_inputs();
      smp();
      chk("single_valid_o", 32'(valid_o), 32'h1);
      chk("single_last_o", 32'(last_o), 32'h1);
      chk("single_gnt_idx", 32'(gnt_idx_o), 32'h2);
      chk("single_locked", 32'(locked_o), 32'h0);
      tick();

      // ---------------- packet lock: 4 flits on input 1, input 3 waiting ----------------
      do_reset();
      for (int s = 0; s < 4; s++) expect_flit(mk(1, s), (s == 3));
      expect_flit(mk(3, 0), 1'b1);
      for (int c = 0; c < 4; c++) begin
         valid_i = 5'b01010;
         last_i  = (c == 3) ? 5'b01010 : 5'b01000;
         flit_i[1] = mk(1, c);
         flit_i[3] = mk(3, 0);
         smp();
         chk("lock_ready_in1", 32'(ready_o), 32'h02);
         if (c > 0) chk("lock_locked", 32'(locked_o), 32'h1);
         tick();
      end
      valid_i = 5'b01000; last_i = 5'b01000; flit_i[3] = mk(3, 0);
      smp();
      chk("lock_ready_in3", 32'(ready_o), 32'h08);
      chk("lock_released", 32'(locked_o), 32'h0);
      tick();
      clear_inputs();
      smp();
      tick();

      // ---------------- fairness: all inputs, 1-flit packets ----------------
      do_reset();
      for (int k = 0; k < 10; k++) expect_flit(32'hF000_0000 | 32'(k % 5), 1'b1);
      for (int k = 0; k < 10; k++) begin
         valid_i = 5'b11111;
         last_i  = 5'b11111;
         for (int i = 0; i < N; i++) flit_i[i] = 32'hF000_0000 | 32'(i);
         smp();
         chk("fair_ready", 32'(ready_o), 32'(5'b00001 << (k % 5)));
         if (k > 0) begin
            chk("fair_valid_o", 32'(valid_o), 32'h1);
            chk("fair_gnt_idx", 32'(gnt_idx_o), 32'((k - 1) % 5));
         end
         tick();
      end
      clear_inputs();
      smp();
      tick();

      // ---------------- backpressure mid-packet on input 2 ----------------
      do_reset();
      for (int s = 0; s < 4; s++) expect_flit(mk(2, s), (s == 3));
      valid_i = 5'b00100; flit_i[2] = mk(2, 0);
      smp();
      chk("bp_ready_first", 32'(ready_o), 32'h04);
      tick();
      flit_i[2] = mk(2, 1);
      smp();
      tick();
      for (int c = 0; c < 3; c++) begin
         ready_i = 1'b0; flit_i[2] = mk(2, 2);
         smp();
         chk("bp_ready_stall", 32'(ready_o), 32'h0);
         chk("bp_locked", 32'(locked_o), 32'h1);
         chk("bp_flit_stable", flit_o, mk(2, 1));
         tick();
      end
      ready_i = 1'b1; flit_i[2] = mk(2, 2);
      smp();
      chk("bp_ready_resume", 32'(ready_o), 32'h04);
      tick();
      flit_i[2] = mk(2, 3); last_i[2] = 1'b1;
      smp();
      tick();
      clear_inputs();
      smp();
      chk("bp_unlocked", 32'(locked_o), 32'h0);
      tick();
      smp();
      chk("bp_drained", 32'(valid_o), 32'h0);
      tick();

      // ---------------- upstream bubble on locked input 3, input 0 waiting ----------------
      do_reset();
      for (int s = 0; s < 3; s++) expect_flit(mk(3, s), (s == 2));
      expect_flit(mk(0, 0), 1'b1);
      valid_i = 5'b01000; flit_i[3] = mk(3, 0);
      smp();
      chk("bub_ready_first", 32'(ready_o), 32'h08);
      tick();
      for (int c = 1; c < 5; c++) begin
         valid_i   = (c < 3) ? 5'b00001 : 5'b01001;
         last_i    = (c == 4) ? 5'b01001 : 5'b00001;
         flit_i[0] = mk(0, 0);
         flit_i[3] = mk(3, (c < 3) ? 1 : c - 2);
         smp();
         chk("bub_ready_locked", 32'(ready_o), 32'h08);
         tick();
      end
      valid_i = 5'b00001; last_i = 5'b00001; flit_i[0] = mk(0, 0);
      smp();
      chk("bub_ready_in0", 32'(ready_o), 32'h01);
      tick();
      clear_inputs();
      smp();
      tick();

      // ---------------- reset mid-packet on input 4 ----------------
      do_reset();
      valid_i = 5'b10000; flit_i[4] = mk(4, 0);
      smp();
      chk("rmp_ready_first", 32'(ready_o), 32'h10);
      tick();
      rst_n = 1'b0; ready_i = 1'b0;
      valid_i = 5'b10001; flit_i[0] = mk(0, 0); last_i = 5'b00001;
      smp();
      chk("rmp_ready_in_reset", 32'(ready_o), 32'h0);
      tick();
      rst_n = 1'b1; ready_i = 1'b1;
      expect_flit(mk(0, 0), 1'b1);
      smp();
      chk("rmp_valid_o", 32'(valid_o), 32'h0);
      chk("rmp_locked", 32'(locked_o), 32'h0);
      chk("rmp_ready_in0", 32'(ready_o), 32'h01);
      tick();
      clear_inputs();
      smp();
      tick();
      smp();
      tick();

      chk("sb_empty", 32'(exp_flit_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_axi_grid_link_arb
